muldiv_unit: RTL

Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the MIPS datapath. It executes MULTU, MULT, DIVU and DIV in both unsigned and signed forms over a configurable operand width. It sits beside the ALU in the execute stage. The control unit starts operations via a start/busy/done handshake, and the result mux reads HI/LO for MFHI/MFLO.

---
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Handshake and HI/LO access bundle between the control unit (master) and the
// iterative multiply/divide unit (slave).
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wd;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, flush, hi_we, lo_we, wd,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush, hi_we, lo_we, wd,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO pair.
// Operands are reduced to magnitudes on accept; signs are reapplied in FIX.
module muldiv_unit #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               busy_q;
   logic               done_q;
   logic               dz_out_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nx;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   a_raw_q;
   logic               is_div_q;
   logic               neg_q;
   logic               sa_q;
   logic               dz_q;

   logic               accept;
   logic               is_signed;
   logic               sa;
   logic               sb;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shl;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
      return en ? (~x + WIDTH'(1)) : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
      return en ? (~x + (2*WIDTH)'(1)) : x;
   endfunction

   assign accept    = (state == IDLE) && bus.start && !bus.flush;
   assign is_signed = SIGNED_EN && bus.op[0];
   assign sa        = is_signed && bus.a[WIDTH-1];
   assign sb        = is_signed && bus.b[WIDTH-1];

   // Upper half of acc is the partial product / running remainder, lower half
   // is the shifting multiplier / dividend-becoming-quotient.
   always_comb begin
      sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
      shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff = shl - {1'b0, b_mag};
      if (is_div_q) begin
         if (!diff[WIDTH]) acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else              acc_nx = {shl[WIDTH-1:0],  acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_nx = {sum, acc[WIDTH-1:1]};
      end
   end

   // Most-negative / -1 needs no special case: the magnitude quotient negates
   // back onto itself and the remainder is zero.
   always_comb begin
      prod_fix = neg_2w(acc, neg_q);
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      if (dz_q) begin
         res_hi = a_raw_q;
         res_lo = '1;
      end else if (is_div_q) begin
         res_lo = neg_w(acc[WIDTH-1:0], neg_q);
         res_hi = neg_w(acc[2*WIDTH-1:WIDTH], sa_q);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         acc      <= {{WIDTH{1'b0}}, neg_w(bus.a, sa)};
         b_mag    <= neg_w(bus.b, sb);
         a_raw_q  <= bus.a;
         is_div_q <= bus.op[1];
         neg_q    <= sa ^ sb;
         sa_q     <= sa;
         dz_q     <= bus.op[1] && (bus.b == '0);
      end else if (state == RUN) begin
         acc <= acc_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_out_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         done_q   <= 1'b0;
         dz_out_q <= 1'b0;
         case (state)
            IDLE: begin
               if (!bus.flush) begin
                  if (bus.start) begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                     cnt    <= CNT_W'(WIDTH - 1);
                  end else begin
                     if (bus.hi_we) hi_q <= bus.wd;
                     if (bus.lo_we) lo_q <= bus.wd;
                  end
               end
            end
            RUN: begin
               if (bus.flush) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            FIX: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               if (!bus.flush) begin
                  hi_q     <= res_hi;
                  lo_q     <= res_lo;
                  done_q   <= 1'b1;
                  dz_out_q <= dz_q;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dz_out_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule
